display_scan_scheduler: RTL and testbench

- Time-multiplexed scan controller for the irrigation controller's 4-digit 7-segment display.
- Drives the view-select line and active-low digit enables feeding the existing segment encoder/decoder.
  - Digit 1 shows the water-level view (Sd=0); digit 2 shows the irrigation-type view (Sd=1); digits 3–4 stay dark.
- Snapshots status inputs once per frame so a frame never tears.
- Blinks the display while an alarm (error or critical level) is latched.

---
 rtl/display_scan_scheduler.sv | 149 ++++++++++++++
 tb/tb_display_scan_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// Scan controller for the irrigation controller's 4-digit 7-segment display:
// slot timing, anti-ghost blanking, per-frame status snapshots and alarm blink.
module display_scan_scheduler #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       nv_critico_i,
  input  logic       nv_baixo_i,
  input  logic       nv_medio_i,
  input  logic       nv_alto_i,
  input  logic       err_i,
  input  logic       bs_i,
  input  logic       vs_i,
  output logic       sd,
  output logic [3:0] seg_d,
  output logic       nv_critico,
  output logic       nv_baixo,
  output logic       nv_medio,
  output logic       nv_alto,
  output logic       err,
  output logic       bs,
  output logic       vs,
  output logic       frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_FRAMES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] p;
  logic [PW-1:0] p_nxt;
  logic [1:0]    slot;
  logic [1:0]    slot_nxt;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_nxt;
  logic          blink_phase;
  logic          blink_phase_nxt;
  logic          frame_end;
  logic          alarm_cur;
  logic          alarm_new;
  logic          lit_nxt;
  logic [3:0]    seg_nxt;

  // The registered frame_tick marks the last cycle of the frame, so it doubles
  // as the snapshot/blink strobe for the edge that closes the frame.
  assign frame_end = frame_tick;
  assign alarm_cur = err | nv_critico;
  assign alarm_new = frame_end ? (err_i | nv_critico_i) : alarm_cur;

  always_comb begin
    state_nxt = en ? SCAN : IDLE;
    p_nxt     = '0;
    slot_nxt  = '0;
    if (en && (state == SCAN)) begin
      if (p == P_LAST) begin
        p_nxt    = '0;
        slot_nxt = slot + 2'd1;
      end else begin
        p_nxt    = p + PW'(1);
        slot_nxt = slot;
      end
    end
  end

  // Blink advances only on frame ends that were already showing an alarm;
  // a frame end whose new snapshot is quiet cancels the blink immediately.
  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    if (!en) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b0;
    end else if (frame_end) begin
      if (!alarm_new) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = 1'b0;
      end else if (alarm_cur) begin
        if (blink_cnt == B_LAST) begin
          blink_cnt_nxt   = '0;
          blink_phase_nxt = ~blink_phase;
        end else begin
          blink_cnt_nxt = blink_cnt + BW'(1);
        end
      end
    end
  end

  // Outputs are decoded from next-cycle p/slot so the flops line up with the
  // counters they describe.
  always_comb begin
    lit_nxt = (state_nxt == SCAN) && (p_nxt >= P_BLANK) && !slot_nxt[1] && !blink_phase_nxt;
    seg_nxt = 4'b1111;
    if (lit_nxt) begin
      seg_nxt[slot_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      p           <= '0;
      slot        <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_d       <= 4'b1111;
      sd          <= 1'b0;
      frame_tick  <= 1'b0;
      nv_critico  <= 1'b0;
      nv_baixo    <= 1'b0;
      nv_medio    <= 1'b0;
      nv_alto     <= 1'b0;
      err         <= 1'b0;
      bs          <= 1'b0;
      vs          <= 1'b0;
    end else begin
      state       <= state_nxt;
      p           <= p_nxt;
      slot        <= slot_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      seg_d       <= seg_nxt;
      sd          <= (state_nxt == SCAN) && (slot_nxt == 2'd1);
      frame_tick  <= (state_nxt == SCAN) && (slot_nxt == 2'd3) && (p_nxt == P_LAST);
      if (frame_end) begin
        nv_critico <= nv_critico_i;
        nv_baixo   <= nv_baixo_i;
        nv_medio   <= nv_medio_i;
        nv_alto    <= nv_alto_i;
        err        <= err_i;
        bs         <= bs_i;
        vs         <= vs_i;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with a small scan geometry
// (8 cycles per slot, 2 blank cycles, 3-frame blink half-period).
module tb_display_scan_scheduler;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       nv_critico_i, nv_baixo_i, nv_medio_i, nv_alto_i, err_i, bs_i, vs_i;
  logic       sd;
  logic [3:0] seg_d;
  logic       nv_critico, nv_baixo, nv_medio, nv_alto, err, bs, vs;
  logic       frame_tick;
  logic [6:0] snap;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic       nv_medio_i;
    logic [3:0] exp_seg;
    logic       exp_sd;
    logic       exp_ft;
    logic       exp_medio;
  } vec_t;

  vec_t       vecs[66];
  logic       blank_f[13];
  logic       exp_err[13];
  logic [3:0] exp_q[$];

  display_scan_scheduler #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .nv_critico_i(nv_critico_i),
    .nv_baixo_i  (nv_baixo_i),
    .nv_medio_i  (nv_medio_i),
    .nv_alto_i   (nv_alto_i),
    .err_i       (err_i),
    .bs_i        (bs_i),
    .vs_i        (vs_i),
    .sd          (sd),
    .seg_d       (seg_d),
    .nv_critico  (nv_critico),
    .nv_baixo    (nv_baixo),
    .nv_medio    (nv_medio),
    .nv_alto     (nv_alto),
    .err         (err),
    .bs          (bs),
    .vs          (vs),
    .frame_tick  (frame_tick)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  assign snap = {nv_critico, nv_baixo, nv_medio, nv_alto, err, bs, vs};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " seg_d"}, 32'(seg_d), 32'hF);
    chk({tag, " sd"}, 32'(sd), 32'h0);
    chk({tag, " frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  // Raise en at a falling edge; returns at the falling edge of SCAN cycle 0.
  task automatic start_scan();
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] e4;
    int         cc;

    for (int c = 0; c < 66; c++) begin
      cc = c % 32;
      vecs[c].en         = 1'b1;
      vecs[c].nv_medio_i = (c >= 5) && (c < 40);
      vecs[c].exp_seg    = (cc >= 2 && cc <= 7)   ? 4'b1110 :
                           (cc >= 10 && cc <= 15) ? 4'b1101 : 4'b1111;
      vecs[c].exp_sd     = (cc >= 8) && (cc <= 15);
      vecs[c].exp_ft     = (cc == 31);
      vecs[c].exp_medio  = (c >= 32) && (c < 64);
    end
    for (int f = 0; f < 13; f++) begin
      blank_f[f] = (f >= 4 && f <= 6) || (f == 10) || (f == 11);
      exp_err[f] = (f >= 1) && (f <= 11);
    end

    // Reset held with en=1 and all inputs high: rst must dominate
    rst = 1'b1;
    en  = 1'b1;
    {nv_critico_i, nv_baixo_i, nv_medio_i, nv_alto_i, err_i, bs_i, vs_i} = 7'h7F;
    repeat (3) begin
      @(negedge clk);
      chk_dark("reset");
      chk("reset snap", 32'(snap), 32'h0);
    end
    rst = 1'b0;
    en  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk_dark("idle");
      chk("idle snap", 32'(snap), 32'h0);
    end
    {nv_critico_i, nv_baixo_i, nv_medio_i, nv_alto_i, err_i, bs_i, vs_i} = 7'h00;

    // Scan timing and snapshot, table-driven over two frames plus two cycles
    start_scan();
    for (int c = 0; c < 66; c++) begin
      chk($sformatf("scan c%0d seg_d", c), 32'(seg_d), 32'(vecs[c].exp_seg));
      chk($sformatf("scan c%0d sd", c), 32'(sd), 32'(vecs[c].exp_sd));
      chk($sformatf("scan c%0d frame_tick", c), 32'(frame_tick), 32'(vecs[c].exp_ft));
      chk($sformatf("scan c%0d snap", c), 32'(snap), 32'(vecs[c].exp_medio) << 4);
      en         = vecs[c].en;
      nv_medio_i = vecs[c].nv_medio_i;
      @(negedge clk);
    end
    en         = 1'b0;
    nv_medio_i = 1'b0;
    repeat (2) @(negedge clk);

    // Blink: err held from cycle 0, released during frame 11
    for (int f = 0; f < 13; f++) exp_q.push_back(blank_f[f] ? 4'b1111 : 4'b1110);
    err_i = 1'b1;
    start_scan();
    for (int f = 0; f < 13; f++) begin
      for (int c = 0; c < 32; c++) begin
        if (c == 0) chk($sformatf("blink f%0d err", f), 32'(err), 32'(exp_err[f]));
        if (c == 4) begin
          e4 = exp_q.pop_front();
          chk($sformatf("blink f%0d slot0 seg_d", f), 32'(seg_d), 32'(e4));
        end
        if (c == 12) begin
          chk($sformatf("blink f%0d slot1 seg_d", f), 32'(seg_d), blank_f[f] ? 32'hF : 32'hD);
          chk($sformatf("blink f%0d slot1 sd", f), 32'(sd), 32'h1);
        end
        if (c == 30) chk($sformatf("blink f%0d c30 frame_tick", f), 32'(frame_tick), 32'h0);
        if (c == 31) begin
          chk($sformatf("blink f%0d frame_tick", f), 32'(frame_tick), 32'h1);
          chk($sformatf("blink f%0d c31 sd", f), 32'(sd), 32'h0);
        end
        if (f == 11 && c == 5) err_i = 1'b0;
        @(negedge clk);
      end
    end
    en = 1'b0;
    repeat (2) @(negedge clk);

    // Enable abort in slot 1, then restart from slot 0 / p=0
    start_scan();
    for (int c = 0; c < 12; c++) @(negedge clk);
    chk("abort c12 seg_d", 32'(seg_d), 32'hD);
    chk("abort c12 sd", 32'(sd), 32'h1);
    en = 1'b0;
    @(negedge clk);
    chk_dark("abort c13");
    repeat (3) begin
      @(negedge clk);
      chk_dark("abort idle");
    end
    start_scan();
    for (int c = 0; c < 11; c++) begin
      if (c == 0 || c == 1) chk($sformatf("restart c%0d seg_d", c), 32'(seg_d), 32'hF);
      if (c == 2) chk("restart c2 seg_d", 32'(seg_d), 32'hE);
      if (c == 8) begin
        chk("restart c8 seg_d", 32'(seg_d), 32'hF);
        chk("restart c8 sd", 32'(sd), 32'h1);
      end
      if (c == 10) chk("restart c10 seg_d", 32'(seg_d), 32'hD);
      @(negedge clk);
    end

    // Async reset between edges in slot 1 (cycle 11)
    chk("pre-rst c11 seg_d", 32'(seg_d), 32'hD);
    #2 rst = 1'b1;
    #1;
    chk("async rst seg_d", 32'(seg_d), 32'hF);
    chk("async rst sd", 32'(sd), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);

    // Async reset inside a blanked frame must clear blink state
    err_i = 1'b1;
    start_scan();
    repeat (4 * 32 + 11) @(negedge clk);
    chk("blank f4 seg_d", 32'(seg_d), 32'hF);
    chk("blank f4 sd", 32'(sd), 32'h1);
    chk("blank f4 err", 32'(err), 32'h1);
    #2 rst = 1'b1;
    err_i = 1'b0;
    #1;
    chk("async rst2 seg_d", 32'(seg_d), 32'hF);
    chk("async rst2 sd", 32'(sd), 32'h0);
    chk("async rst2 snap", 32'(snap), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("post-rst c4 seg_d", 32'(seg_d), 32'hE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
